// File: rtl/exe_alu_mdu.sv
// exe_alu_mdu: execute stage ALU plus iterative multiply/divide owning HI/LO.
// Define FAST_MULT_EN for single-cycle MULT/MULTU (DIV/DIVU stay iterative).
module exe_alu_mdu #(
    parameter int MDU_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] iBusA,
    input  logic [31:0] iBusB,
    input  logic [31:0] iimm,
    input  logic [31:0] isa,
    input  logic        iALUSrc,
    input  logic [5:0]  iALUop,
    input  logic        iRegWr,
    input  logic [4:0]  iwaddr,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] oResult,
    output logic        oRegWr,
    output logic [4:0]  owaddr,
    output logic        oOverflow,
    output logic [31:0] oHI,
    output logic [31:0] oLO
);
    localparam logic [5:0] OP_ADDU  = 6'h00;
    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUBU  = 6'h02;
    localparam logic [5:0] OP_SUB   = 6'h03;
    localparam logic [5:0] OP_AND   = 6'h04;
    localparam logic [5:0] OP_OR    = 6'h05;
    localparam logic [5:0] OP_XOR   = 6'h06;
    localparam logic [5:0] OP_NOR   = 6'h07;
    localparam logic [5:0] OP_SLT   = 6'h08;
    localparam logic [5:0] OP_SLTU  = 6'h09;
    localparam logic [5:0] OP_SLL   = 6'h0A;
    localparam logic [5:0] OP_SRL   = 6'h0B;
    localparam logic [5:0] OP_SRA   = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0D;
    localparam logic [5:0] OP_MULT  = 6'h10;
    localparam logic [5:0] OP_MULTU = 6'h11;
    localparam logic [5:0] OP_DIV   = 6'h12;
    localparam logic [5:0] OP_DIVU  = 6'h13;
    localparam logic [5:0] OP_MFHI  = 6'h14;
    localparam logic [5:0] OP_MFLO  = 6'h15;
    localparam logic [5:0] OP_MTHI  = 6'h16;
    localparam logic [5:0] OP_MTLO  = 6'h17;
    localparam logic [6:0] LAST     = 7'(MDU_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, stateNext;

    logic [31:0] opB, sum, diff, aluRes, aMag, bMag;
    logic        ovf, isMul, isDiv, isMdu, sgnOp, noWr;
    logic        accept, mduStart, unusedSa;
    logic [6:0]  cnt;
    logic [31:0] mdHi, mdLo, mdOpd, mdRs;
    logic        mdIsDiv, mdNeg, mdRemNeg, mdZero;
    logic [32:0] mulSum, divTry;
    logic [63:0] mulRes;
    logic [31:0] hiDone, loDone;

    assign unusedSa = ^isa[31:5];
    assign opB      = iALUSrc ? iimm : iBusB;
    assign sum      = iBusA + opB;
    assign diff     = iBusA - opB;
    assign isMul    = (iALUop == OP_MULT) || (iALUop == OP_MULTU);
    assign isDiv    = (iALUop == OP_DIV) || (iALUop == OP_DIVU);
    assign sgnOp    = (iALUop == OP_MULT) || (iALUop == OP_DIV);
    assign noWr     = isMul || isDiv || (iALUop == OP_MTHI) || (iALUop == OP_MTLO);
`ifdef FAST_MULT_EN
    logic [63:0] fastProd;
    assign isMdu    = isDiv;
    assign fastProd = {{32{sgnOp & iBusA[31]}}, iBusA} * {{32{sgnOp & opB[31]}}, opB};
`else
    assign isMdu    = isMul || isDiv;
`endif
    assign accept   = in_valid && !flush && (state == IDLE);
    assign mduStart = accept && isMdu;
    assign aMag     = (sgnOp && iBusA[31]) ? -iBusA : iBusA;
    assign bMag     = (sgnOp && opB[31]) ? -opB : opB;

    always_comb begin
        aluRes = '0;
        ovf    = 1'b0;
        unique case (iALUop)
            OP_ADDU:  aluRes = sum;
            OP_ADD: begin
                aluRes = sum;
                ovf    = (iBusA[31] == opB[31]) && (sum[31] != iBusA[31]);
            end
            OP_SUBU:  aluRes = diff;
            OP_SUB: begin
                aluRes = diff;
                ovf    = (iBusA[31] != opB[31]) && (diff[31] != iBusA[31]);
            end
            OP_AND:   aluRes = iBusA & opB;
            OP_OR:    aluRes = iBusA | opB;
            OP_XOR:   aluRes = iBusA ^ opB;
            OP_NOR:   aluRes = ~(iBusA | opB);
            OP_SLT:   aluRes = {31'd0, $signed(iBusA) < $signed(opB)};
            OP_SLTU:  aluRes = {31'd0, iBusA < opB};
            OP_SLL:   aluRes = opB << isa[4:0];
            OP_SRL:   aluRes = opB >> isa[4:0];
            OP_SRA:   aluRes = $signed(opB) >>> isa[4:0];
            OP_LUI:   aluRes = {opB[15:0], 16'd0};
            OP_MFHI:  aluRes = oHI;
            OP_MFLO:  aluRes = oLO;
            OP_MTHI:  aluRes = iBusA;
            OP_MTLO:  aluRes = iBusA;
            default:  aluRes = '0;
        endcase
    end

    // One shift-add or restore-subtract step per BUSY cycle.
    assign mulSum = {1'b0, mdHi} + (mdLo[0] ? {1'b0, mdOpd} : 33'd0);
    assign divTry = {mdHi, mdLo[31]} - {1'b0, mdOpd};
    assign mulRes = mdNeg ? -{mdHi, mdLo} : {mdHi, mdLo};

    always_comb begin
        hiDone = mulRes[63:32];
        loDone = mulRes[31:0];
        if (mdIsDiv) begin
            if (mdZero) begin
                hiDone = mdRs;
                loDone = '1;
            end else begin
                hiDone = mdRemNeg ? -mdHi : mdHi;
                loDone = mdNeg ? -mdLo : mdLo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mduStart) begin
                    stateNext = BUSY;
                    stall     = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt == LAST) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (flush) stateNext = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            oResult   <= '0;
            oRegWr    <= 1'b0;
            owaddr    <= '0;
            oOverflow <= 1'b0;
            oHI       <= '0;
            oLO       <= '0;
            cnt       <= '0;
            mdHi      <= '0;
            mdLo      <= '0;
            mdOpd     <= '0;
            mdRs      <= '0;
            mdIsDiv   <= 1'b0;
            mdNeg     <= 1'b0;
            mdRemNeg  <= 1'b0;
            mdZero    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            cnt       <= (state == BUSY) ? cnt + 7'd1 : 7'd0;
            if (!flush) begin
                if (accept && !isMdu) begin
                    out_valid <= 1'b1;
                    oResult   <= aluRes;
                    oRegWr    <= iRegWr && !ovf && !noWr;
                    oOverflow <= ovf;
                    owaddr    <= iwaddr;
                    if (iALUop == OP_MTHI) oHI <= iBusA;
                    if (iALUop == OP_MTLO) oLO <= iBusA;
`ifdef FAST_MULT_EN
                    if (isMul) begin
                        oHI <= fastProd[63:32];
                        oLO <= fastProd[31:0];
                    end
`endif
                end
                if (mduStart) begin
                    mdHi     <= '0;
                    mdLo     <= isDiv ? aMag : bMag;
                    mdOpd    <= isDiv ? bMag : aMag;
                    mdRs     <= iBusA;
                    mdIsDiv  <= isDiv;
                    mdNeg    <= sgnOp && (iBusA[31] ^ opB[31]);
                    mdRemNeg <= sgnOp && iBusA[31];
                    mdZero   <= (opB == 32'd0);
                end
                if (state == BUSY) begin
                    if (!mdIsDiv) begin
                        mdHi <= mulSum[32:1];
                        mdLo <= {mulSum[0], mdLo[31:1]};
                    end else if (!divTry[32]) begin
                        mdHi <= divTry[31:0];
                        mdLo <= {mdLo[30:0], 1'b1};
                    end else begin
                        mdHi <= {mdHi[30:0], mdLo[31]};
                        mdLo <= {mdLo[30:0], 1'b0};
                    end
                end
                if (state == DONE) begin
                    out_valid <= 1'b1;
                    oResult   <= loDone;
                    oRegWr    <= 1'b0;
                    oOverflow <= 1'b0;
                    oHI       <= hiDone;
                    oLO       <= loDone;
                end
            end
        end
    end
endmodule
